// File: rtl/junction_pkg.sv
// Shared types and constants for the four-way junction phase scheduler.
package junction_pkg;

    typedef enum logic [1:0] {
        PH_ALL_RED = 2'd0,
        PH_GREEN   = 2'd1,
        PH_YELLOW  = 2'd2
    } phase_e;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    localparam int GREEN_MIN_DEF = 3;
    localparam int GREEN_MAX_DEF = 30;
    localparam int YELLOW_T_DEF  = 5;
    localparam int ALLRED_T_DEF  = 2;
    localparam int CNT_W_DEF     = 16;

    function automatic logic [3:0] dirMask(input logic [1:0] dir);
        dirMask = 4'b0001 << dir;
    endfunction

endpackage

// File: rtl/junction_phase_scheduler_rr_pick.sv
// Combinational 4-way round-robin selector: first requester strictly after `last`,
// wrapping W -> N, with `last` itself checked at lowest priority.
module rr_pick
    import junction_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] grant,
    output logic       valid
);

    // Walk from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        grant = last;
        valid = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            if (req[last + 2'(k)]) begin
                grant = last + 2'(k);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/junction_phase_scheduler.sv
// Demand-driven green/yellow/all-red sequencer for a four-way junction, timed in EN strobes.
// Optional emergency preemption (PRE_REQ/PRE_DIR/PRE_ACT) is built when EMERGENCY_PREEMPT_EN is defined.
//
//   state      | meaning
//   PH_ALL_RED | every approach red; grant next requester when clearance expires
//   PH_GREEN   | GREEN[PHASE] lit; ends at GREEN_MAX or at GREEN_MIN with other demand
//   PH_YELLOW  | YELLOW[PHASE] lit for YELLOW_T strobes
module junction_phase_scheduler
    import junction_pkg::*;
#(
    parameter int GREEN_MIN = GREEN_MIN_DEF,
    parameter int GREEN_MAX = GREEN_MAX_DEF,
    parameter int YELLOW_T  = YELLOW_T_DEF,
    parameter int ALLRED_T  = ALLRED_T_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic [3:0] REQ,
    output logic [3:0] RED,
    output logic [3:0] YELLOW,
    output logic [3:0] GREEN,
    output logic [1:0] PHASE
`ifdef EMERGENCY_PREEMPT_EN
    ,
    input  logic       PRE_REQ,
    input  logic [1:0] PRE_DIR,
    output logic       PRE_ACT
`endif
);

    localparam logic [CNT_W-1:0] T_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] T_GMAX   = CNT_W'(GREEN_MAX);
    localparam logic [CNT_W-1:0] T_YEL    = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] T_AR     = CNT_W'(ALLRED_T);
    // Remaining-count at or below which this strobe completes GREEN_MIN.
    localparam logic [CNT_W-1:0] T_MIN_TC = CNT_W'(GREEN_MAX - GREEN_MIN + 1);

    phase_e           state, stateNext;
    logic [CNT_W-1:0] tmr, tmrNext;
    logic [1:0]       phaseNext;
    logic             minMet, minMetNext;
    logic             fresh, freshNext;
    logic [1:0]       lastDir, pickIdx;
    logic             pickValid;
    logic             otherReq;
    logic [3:0]       greenNext, yellowNext;
    logic             preReq;
    logic [1:0]       preDir;

`ifdef EMERGENCY_PREEMPT_EN
    assign preReq = PRE_REQ;
    assign preDir = PRE_DIR;
`else
    assign preReq = 1'b0;
    assign preDir = DIR_N;
`endif

    // After reset the search must start at N, i.e. as if W was served last.
    assign lastDir  = fresh ? DIR_W : PHASE;
    assign otherReq = |(REQ & ~dirMask(PHASE));

    rr_pick u_pick (
        .req   (REQ),
        .last  (lastDir),
        .grant (pickIdx),
        .valid (pickValid)
    );

    always_comb begin
        stateNext  = state;
        phaseNext  = PHASE;
        tmrNext    = tmr;
        minMetNext = minMet;
        freshNext  = fresh;
        case (state)
            PH_ALL_RED: begin
                if (EN) begin
                    if (tmr > T_ONE) begin
                        tmrNext = tmr - T_ONE;
                    end else if (preReq || pickValid) begin
                        stateNext  = PH_GREEN;
                        phaseNext  = preReq ? preDir : pickIdx;
                        tmrNext    = T_GMAX;
                        minMetNext = 1'b0;
                        freshNext  = 1'b0;
                    end
                end
            end
            PH_GREEN: begin
                if (preReq && (preDir != PHASE)) begin
                    stateNext = PH_YELLOW;
                    tmrNext   = T_YEL;
                end else if (preReq) begin
                    minMetNext = 1'b1;
                end else if (EN) begin
                    if ((tmr == T_ONE) || ((minMet || (tmr <= T_MIN_TC)) && otherReq)) begin
                        stateNext = PH_YELLOW;
                        tmrNext   = T_YEL;
                    end else begin
                        tmrNext = tmr - T_ONE;
                    end
                end
            end
            PH_YELLOW: begin
                if (EN) begin
                    if (tmr == T_ONE) begin
                        stateNext = PH_ALL_RED;
                        tmrNext   = T_AR;
                    end else begin
                        tmrNext = tmr - T_ONE;
                    end
                end
            end
            default: begin
                stateNext = PH_ALL_RED;
                tmrNext   = T_AR;
            end
        endcase
        greenNext  = (stateNext == PH_GREEN)  ? dirMask(phaseNext) : 4'b0000;
        yellowNext = (stateNext == PH_YELLOW) ? dirMask(phaseNext) : 4'b0000;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= PH_ALL_RED;
            tmr    <= T_AR;
            PHASE  <= DIR_N;
            minMet <= 1'b0;
            fresh  <= 1'b1;
            RED    <= 4'b1111;
            YELLOW <= 4'b0000;
            GREEN  <= 4'b0000;
        end else begin
            state  <= stateNext;
            tmr    <= tmrNext;
            PHASE  <= phaseNext;
            minMet <= minMetNext;
            fresh  <= freshNext;
            RED    <= ~(greenNext | yellowNext);
            YELLOW <= yellowNext;
            GREEN  <= greenNext;
        end
    end

`ifdef EMERGENCY_PREEMPT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            PRE_ACT <= 1'b0;
        end else begin
            PRE_ACT <= preReq && (stateNext == PH_GREEN) && (phaseNext == preDir);
        end
    end
`endif

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// Directed bench for junction_phase_scheduler with a strobe-level reference model.
module tb_junction_phase_scheduler;

    localparam int GMIN = 3;
    localparam int GMAX = 6;
    localparam int YT   = 2;
    localparam int ART  = 1;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic       EN    = 1'b0;
    logic [3:0] REQ   = 4'b0000;
    logic [3:0] RED, YELLOW, GREEN;
    logic [1:0] PHASE;
    logic       PRE_REQ = 1'b0;
    logic [1:0] PRE_DIR = 2'd0;
`ifdef EMERGENCY_PREEMPT_EN
    logic       PRE_ACT;
`endif

    int nVec = 0;
    int nBad = 0;

    always #5 CLK = ~CLK;

    junction_phase_scheduler #(
        .GREEN_MIN (GMIN),
        .GREEN_MAX (GMAX),
        .YELLOW_T  (YT),
        .ALLRED_T  (ART),
        .CNT_W     (16)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .EN     (EN),
        .REQ    (REQ),
        .RED    (RED),
        .YELLOW (YELLOW),
        .GREEN  (GREEN),
        .PHASE  (PHASE)
`ifdef EMERGENCY_PREEMPT_EN
        ,
        .PRE_REQ (PRE_REQ),
        .PRE_DIR (PRE_DIR),
        .PRE_ACT (PRE_ACT)
`endif
    );

    // Reference model: 0 = all-red, 1 = green, 2 = yellow; elapsed counts strobes up.
    int   mState   = 0;
    int   mElapsed = 0;
    int   mPhase   = 0;
    bit   mFresh   = 1'b1;
    bit   mMinMet  = 1'b0;
    bit   mPreAct  = 1'b0;

    always @(posedge CLK or negedge RST_N) begin
        int g, d;
        logic [3:0] others;
        if (!RST_N) begin
            mState = 0; mElapsed = 0; mPhase = 0;
            mFresh = 1'b1; mMinMet = 1'b0; mPreAct = 1'b0;
        end else begin
            case (mState)
                0: if (EN) begin
                    mElapsed++;
                    if (mElapsed >= ART) begin
                        g = -1;
                        if (PRE_REQ) g = int'(PRE_DIR);
                        else for (int k = 0; k < 4; k++) begin
                            d = mFresh ? k : (mPhase + 1 + k) % 4;
                            if (g < 0 && REQ[d]) g = d;
                        end
                        if (g >= 0) begin
                            mState = 1; mPhase = g; mElapsed = 0; mFresh = 1'b0; mMinMet = 1'b0;
                        end
                    end
                end
                1: begin
                    if (PRE_REQ && int'(PRE_DIR) != mPhase) begin
                        mState = 2; mElapsed = 0;
                    end else if (PRE_REQ) begin
                        mMinMet = 1'b1;
                    end else if (EN) begin
                        mElapsed++;
                        others = REQ;
                        others[mPhase] = 1'b0;
                        if (mElapsed >= GMAX || ((mElapsed >= GMIN || mMinMet) && others != 4'b0000)) begin
                            mState = 2; mElapsed = 0;
                        end
                    end
                end
                default: if (EN) begin
                    mElapsed++;
                    if (mElapsed >= YT) begin
                        mState = 0; mElapsed = 0;
                    end
                end
            endcase
            mPreAct = PRE_REQ && mState == 1 && mPhase == int'(PRE_DIR);
        end
    end

    function automatic logic [3:0] bitOf(input int dir);
        logic [3:0] m;
        m = 4'b0000;
        m[dir] = 1'b1;
        return m;
    endfunction

    task automatic check4(input string name, input logic [3:0] got, input logic [3:0] exp);
        nVec++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        logic [3:0] expG, expY;
        bit okInv;
        expG = (mState == 1) ? bitOf(mPhase) : 4'b0000;
        expY = (mState == 2) ? bitOf(mPhase) : 4'b0000;
        check4("green", GREEN, expG);
        check4("yellow", YELLOW, expY);
        check4("red", RED, ~(expG | expY));
        check4("phase", {2'b00, PHASE}, 4'(mPhase));
`ifdef EMERGENCY_PREEMPT_EN
        check4("pre_act", {3'b000, PRE_ACT}, {3'b000, mPreAct});
`endif
        okInv = ($countones(~RED) <= 1) && ((RED ^ YELLOW ^ GREEN) == 4'b1111)
                && (((RED & YELLOW) | (RED & GREEN) | (YELLOW & GREEN)) == 4'b0000);
        check4("invariant", {3'b000, okInv}, 4'b0001);
    end

    task automatic tick(input logic en);
        @(negedge CLK);
        EN = en;
    endtask

    task automatic strobe(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b1);
            tick(1'b0);
            tick(1'b0);
            tick(1'b0);
        end
    endtask

    task automatic doReset();
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check4("lit_rst_red", RED, 4'b1111);
        check4("lit_rst_yellow", YELLOW, 4'b0000);
        check4("lit_rst_green", GREEN, 4'b0000);
        check4("lit_rst_phase", {2'b00, PHASE}, 4'b0000);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] order [4];
        order = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

        repeat (3) @(negedge CLK);
        check4("lit_init_red", RED, 4'b1111);
        check4("lit_init_green", GREEN, 4'b0000);
        RST_N = 1'b1;

        // No demand: stays all-red; a pulse between strobes is not latched.
        strobe(2);
        check4("lit_idle_red", RED, 4'b1111);
        REQ = 4'b0010;
        tick(1'b0);
        REQ = 4'b0000;
        strobe(1);
        check4("lit_pulse_red", RED, 4'b1111);

        // First grant searches from N; only W requesting.
        REQ = 4'b1000;
        strobe(1);
        check4("lit_w_green", GREEN, 4'b1000);
        check4("lit_w_phase", {2'b00, PHASE}, 4'b0011);
        doReset();

        // Lone requester runs to GREEN_MAX and is re-granted.
        REQ = 4'b0001;
        strobe(1);
        check4("lit_n_green", GREEN, 4'b0001);
        strobe(5);
        check4("lit_n_green5", GREEN, 4'b0001);
        strobe(1);
        check4("lit_n_yel", YELLOW, 4'b0001);
        strobe(1);
        check4("lit_n_yel2", YELLOW, 4'b0001);
        strobe(1);
        check4("lit_n_allred", RED, 4'b1111);
        strobe(1);
        check4("lit_n_regrant", GREEN, 4'b0001);

        // Competing S demand cuts N at GREEN_MIN.
        REQ = 4'b0101;
        strobe(2);
        check4("lit_ns_green", GREEN, 4'b0001);
        strobe(1);
        check4("lit_ns_yel", YELLOW, 4'b0001);
        strobe(2);
        check4("lit_ns_allred", RED, 4'b1111);
        strobe(1);
        check4("lit_s_green", GREEN, 4'b0100);
        check4("lit_s_phase", {2'b00, PHASE}, 4'b0010);

        doReset();

        // Full demand: round robin N, E, S, W, N, each GREEN_MIN long.
        REQ = 4'b1111;
        strobe(1);
        check4("lit_rr_n", GREEN, 4'b0001);
        for (int i = 0; i < 4; i++) begin
            strobe(6);
            check4("lit_rr_step", GREEN, order[i]);
        end

        // Freeze with EN low, then resume at the same count.
        strobe(1);
        repeat (100) tick(1'b0);
        check4("lit_frz_green", GREEN, 4'b0001);
        strobe(1);
        check4("lit_frz_green2", GREEN, 4'b0001);
        strobe(1);
        check4("lit_frz_yel", YELLOW, 4'b0001);

`ifdef EMERGENCY_PREEMPT_EN
        doReset();
        REQ = 4'b0001;
        PRE_DIR = 2'd2;
        strobe(1);
        check4("lit_pre_n", GREEN, 4'b0001);
        PRE_REQ = 1'b1;
        tick(1'b0);
        check4("lit_pre_yel", YELLOW, 4'b0001);
        strobe(2);
        check4("lit_pre_allred", RED, 4'b1111);
        strobe(1);
        check4("lit_pre_s", GREEN, 4'b0100);
        check4("lit_pre_act", {3'b000, PRE_ACT}, 4'b0001);
        strobe(8);
        check4("lit_pre_hold", GREEN, 4'b0100);
        PRE_REQ = 1'b0;
        tick(1'b0);
        check4("lit_pre_drop", {3'b000, PRE_ACT}, 4'b0000);
        check4("lit_pre_drop_g", GREEN, 4'b0100);
        strobe(1);
        check4("lit_pre_after", YELLOW, 4'b0100);
`endif

        repeat (4) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule

// File: doc/junction_phase_scheduler.md
# junction_phase_scheduler

Demand-driven phase scheduler for a four-way junction (N, E, S, W). It sequences one shared green phase among the four approaches. Each served approach goes through green, yellow and all-red clearance, and by construction no two approaches are ever non-red together. Timing is counted in EN strobes (the junction timebase), and service order is round-robin over approaches that are requesting. Outputs drive the per-approach lamp registers directly.

## Interface
- GREEN_MIN, default 3: minimum green length in EN strobes (≥1).
- GREEN_MAX, default 30: maximum green length in strobes (≥ GREEN_MIN).
- YELLOW_T, default 5: yellow length in strobes (≥1).
- ALLRED_T, default 2: all-red clearance length in strobes (≥1).
- CNT_W, default 16: width of the timer counters; must hold GREEN_MAX.
- CLK  input  1  single clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- EN  input  1  timebase strobe; timers advance only on edges where EN=1.
- REQ  input  4  demand per approach; bit0=N, 1=E, 2=S, 3=W; level, sampled each edge.
- RED / YELLOW / GREEN  output  4 each  registered lamp drives, same bit order.
- PHASE  output  2  index of the last or current served approach.
- PRE_REQ  input  1  preemption request (only with EMERGENCY_PREEMPT_EN).
- PRE_DIR  input  2  preempted approach (only with EMERGENCY_PREEMPT_EN).
- PRE_ACT  output  1  preempted green active (only with EMERGENCY_PREEMPT_EN).

## Operation
- Three states: ALL_RED, GREEN, YELLOW.
- Reset values: state ALL_RED with timer loaded to ALLRED_T; RED=4'b1111, YELLOW=0, GREEN=0, PHASE=0, PRE_ACT=0.
- The first grant after reset searches from N (bit0).
- ALL_RED:
  - All RED bits are 1.
  - At expiry, pick the first requesting approach cyclically from PHASE+1 (from bit0 after reset). Then load PHASE and enter GREEN.
  - If REQ=0 at expiry, stay in ALL_RED and re-evaluate on every later strobe.
- GREEN:
  - Only GREEN[PHASE]=1; the other approaches are red.
  - The elapsed counter counts strobes.
  - Go to YELLOW on the strobe where elapsed reaches GREEN_MAX.
  - Also go to YELLOW on the strobe where elapsed ≥ GREEN_MIN and REQ has any bit set other than PHASE.
  - The served approach's own REQ never ends or extends the phase.
- YELLOW:
  - Only YELLOW[PHASE]=1.
  - After YELLOW_T strobes, go to ALL_RED and load ALLRED_T.
- Invariant: at most one approach is non-red, and exactly one of RED/YELLOW/GREEN is set per approach.
- Reset mid-operation: all outputs immediately return to their reset values (asynchronous). No partial yellow is completed.

## Timing
- A phase of length T covers exactly T strobes. The transition happens on the clock edge where EN=1 and the T-th strobe of that phase is sampled.
- Lamp outputs are registered and change on that same edge as the state. There is no extra latency.
- With EN=0, state, timers and outputs are frozen.
- REQ is sampled only on the transition edge. REQ pulses that fall between strobes are not latched.
- Round-robin wraps from W (3) to N (0).

## Configuration
- EMERGENCY_PREEMPT_EN defined: the PRE_REQ, PRE_DIR and PRE_ACT ports exist. While PRE_REQ=1:
  - GREEN of another approach goes to YELLOW on the next clock edge, regardless of EN or GREEN_MIN.
  - YELLOW and ALL_RED complete normally.
  - At ALL_RED expiry, PRE_DIR is granted regardless of REQ or round-robin.
  - While PRE_DIR is green, the green timer holds and PRE_ACT=1.
  - When PRE_REQ falls, the green is treated as having met GREEN_MIN and resumes normal timing. PRE_ACT=0 on the same edge.
- EMERGENCY_PREEMPT_EN not defined: these ports are absent and only normal scheduling applies.

## Structure
- Package junction_pkg:
  - typedef phase_e {PH_ALL_RED, PH_GREEN, PH_YELLOW}.
  - Constants DIR_N=0, DIR_E=1, DIR_S=2, DIR_W=3.
  - Default timing constants.
- One sub-module, rr_pick: combinational 4-way round-robin selector. Inputs are REQ and the last PHASE; outputs are the grant index and a valid flag.

## Test plan
Bench parameters: GREEN_MIN=3, GREEN_MAX=6, YELLOW_T=2, ALLRED_T=1, EN strobing every 4 clocks.
- Reset: drop RST_N mid-GREEN -> RED=1111, YELLOW=0, GREEN=0, PHASE=0 with no clock edge needed.
- REQ=0001 held -> after 1 strobe GREEN=0001 for 6 strobes, YELLOW=0001 for 2, all-red for 1, then GREEN=0001 again.
- REQ=0101 -> N green 3 strobes, yellow 2, all-red 1, then GREEN=0100, PHASE=2.
- REQ=1111 -> greens in order N, E, S, W, N, each 3 strobes. Never more than one non-red bit.
- EN=0 for 100 clocks during GREEN with REQ=1111 -> outputs unchanged, then timing resumes at the same count.
- EMERGENCY_PREEMPT_EN, N green at strobe 1, PRE_REQ=1, PRE_DIR=2 -> YELLOW=0001 next clock, 2 strobes yellow, 1 all-red, GREEN=0100 with PRE_ACT=1 held until PRE_REQ falls.
